ysyx_23060136_exu_branch_bht: RTL and testbench

Parametrised successor to the EXU2 branch resolver, with the branch history table (BHT) built into the block.
- Holds a table of saturating counters that IFU reads each cycle to get a taken/not-taken prediction.
- Resolves branches arriving from EXU2, trains the table and issues a registered redirect and flush.
- Sits between IFU (lookup port) and EXU2 (resolve port); replaces the separate combinational resolver plus external BHT.

---
 rtl/ysyx_23060136_bht_pkg.sv | 22 ++
 rtl/ysyx_23060136_bht_table.sv | 63 ++++++
 rtl/ysyx_23060136_exu_branch_bht.sv | 121 ++++++++++++
 tb/tb_ysyx_23060136_exu_branch_bht.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060136_bht_pkg.sv
// Shared types and the saturating-counter helper for the EXU branch BHT.
// Module instances size their own index from BHT_DEPTH; the typedefs here describe the default build.
package ysyx_23060136_bht_pkg;

   localparam int unsigned BHT_DEPTH_DEF = 64;
   localparam int unsigned IDX_W         = $clog2(BHT_DEPTH_DEF);
   localparam int unsigned CNT_W_MAX     = 4;

   typedef logic [IDX_W-1:0]     idx_t;
   typedef logic [CNT_W_MAX-1:0] cnt_t;

   // cnt is zero-extended to CNT_W_MAX; cnt_w selects the real counter width.
   function automatic cnt_t sat_update(input cnt_t cnt, input logic taken, input int unsigned cnt_w);
      cnt_t lim;
      lim = cnt_t'((32'd1 << cnt_w) - 32'd1);
      if (taken) begin
         return (cnt == lim) ? cnt : cnt + 1'b1;
      end
      return (cnt == '0) ? cnt : cnt - 1'b1;
   endfunction

endpackage

// File: rtl/ysyx_23060136_bht_table.sv
// Saturating-counter array with a registered write port and a bypassed combinational read port.
module ysyx_23060136_bht_table
   import ysyx_23060136_bht_pkg::*;
#(
   parameter int unsigned DEPTH    = 64,
   parameter int unsigned TBL_IDX_W = 6,
   parameter int unsigned CNT_W    = 2,
   parameter int unsigned CNT_INIT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [TBL_IDX_W-1:0] wr_idx,
   input  logic                 wr_taken,
   input  logic [TBL_IDX_W-1:0] rd_idx,
   output logic                 rd_taken
);

   logic [CNT_W-1:0] cnt_q [DEPTH];
   logic [CNT_W-1:0] cnt_d [DEPTH];
   logic [CNT_W-1:0] wr_val;
   logic [CNT_W-1:0] rd_val;
   cnt_t             cur_ext;
   cnt_t             new_ext;

   // Back-to-back updates need no forwarding: the previous write has landed before this read.
   always_comb begin
      cur_ext              = '0;
      cur_ext[CNT_W-1:0]   = cnt_q[wr_idx];
      new_ext              = sat_update(cur_ext, wr_taken, CNT_W);
      wr_val               = new_ext[CNT_W-1:0];
   end

   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      if (wr_en) begin
         cnt_d[wr_idx] = wr_val;
      end
   end

   always_comb begin
      rd_val = cnt_q[rd_idx];
      if (wr_en && (wr_idx == rd_idx)) begin
         rd_val = wr_val;
      end
      rd_taken = rd_val[CNT_W-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt_q[i] <= CNT_W'(CNT_INIT);
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

endmodule

// File: rtl/ysyx_23060136_exu_branch_bht.sv
// EXU branch resolver with built-in BHT: IFU lookup, EXU2 resolve, registered redirect/flush.
// Define YSYX_23060136_BHT_PERF_EN to build the resolved-branch and mispredict counters.
module ysyx_23060136_exu_branch_bht
   import ysyx_23060136_bht_pkg::*;
#(
   parameter int unsigned BITS_W    = 32,
   parameter int unsigned BHT_DEPTH = 64,
   parameter int unsigned CNT_W     = 2,
   parameter int unsigned CNT_INIT  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BITS_W-1:0] IFU_pc,
   output logic              IFU_pre_take,
   input  logic              EXU2_valid,
   input  logic              EXU2_is_branch,
   input  logic [BITS_W-1:0] EXU2_pc,
   input  logic              EXU2_jump,
   input  logic              EXU2_pre_take,
   input  logic [BITS_W-1:0] EXU2_target,
   output logic              redirect_valid,
   output logic [BITS_W-1:0] redirect_pc,
   output logic              BRANCH_flushIF,
   output logic              BRANCH_flushID,
   output logic              BRANCH_flushEX1,
   output logic [31:0]       perf_branch_cnt,
   output logic [31:0]       perf_miss_cnt
);

   localparam int unsigned TBL_IDX_W = $clog2(BHT_DEPTH);

   logic [TBL_IDX_W-1:0] ifu_idx, exu_idx;
   logic [TBL_IDX_W-1:0] upd_idx_q, upd_idx_d;
   logic                 upd_valid_q, upd_valid_d;
   logic                 upd_taken_q, upd_taken_d;
   logic                 redirect_valid_q, redirect_valid_d;
   logic [BITS_W-1:0]    redirect_pc_q, redirect_pc_d;
   logic                 squash, fire, miss;
   logic                 ifu_pc_unused;

   assign ifu_idx       = IFU_pc[TBL_IDX_W+1:2];
   assign exu_idx       = EXU2_pc[TBL_IDX_W+1:2];
   assign ifu_pc_unused = ^{IFU_pc[BITS_W-1:TBL_IDX_W+2], IFU_pc[1:0]};

   // Anything arriving while a redirect is visible is wrong-path.
   assign squash = redirect_valid_q;
   assign fire   = EXU2_valid & EXU2_is_branch & ~squash;
   assign miss   = fire & (EXU2_jump ^ EXU2_pre_take);

   always_comb begin
      upd_valid_d      = fire;
      upd_idx_d        = fire ? exu_idx : upd_idx_q;
      upd_taken_d      = fire ? EXU2_jump : upd_taken_q;
      redirect_valid_d = miss;
      redirect_pc_d    = EXU2_jump ? EXU2_target : EXU2_pc + BITS_W'(4);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         upd_valid_q      <= 1'b0;
         upd_idx_q        <= '0;
         upd_taken_q      <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         upd_valid_q      <= upd_valid_d;
         upd_idx_q        <= upd_idx_d;
         upd_taken_q      <= upd_taken_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   ysyx_23060136_bht_table #(
      .DEPTH     (BHT_DEPTH),
      .TBL_IDX_W (TBL_IDX_W),
      .CNT_W     (CNT_W),
      .CNT_INIT  (CNT_INIT)
   ) u_table (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (upd_valid_q),
      .wr_idx   (upd_idx_q),
      .wr_taken (upd_taken_q),
      .rd_idx   (ifu_idx),
      .rd_taken (IFU_pre_take)
   );

   assign redirect_valid  = redirect_valid_q;
   assign redirect_pc     = redirect_pc_q;
   assign BRANCH_flushIF  = redirect_valid_q;
   assign BRANCH_flushID  = redirect_valid_q;
   assign BRANCH_flushEX1 = redirect_valid_q;

`ifdef YSYX_23060136_BHT_PERF_EN
   logic [31:0] perf_branch_q, perf_branch_d;
   logic [31:0] perf_miss_q, perf_miss_d;

   always_comb begin
      perf_branch_d = perf_branch_q + {31'd0, fire};
      perf_miss_d   = perf_miss_q + {31'd0, miss};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_branch_q <= '0;
         perf_miss_q   <= '0;
      end else begin
         perf_branch_q <= perf_branch_d;
         perf_miss_q   <= perf_miss_d;
      end
   end

   assign perf_branch_cnt = perf_branch_q;
   assign perf_miss_cnt   = perf_miss_q;
`else
   assign perf_branch_cnt = '0;
   assign perf_miss_cnt   = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060136_exu_branch_bht.sv
// Directed self-checking bench for ysyx_23060136_exu_branch_bht (BHT_DEPTH=4 to exercise aliasing).
module tb_ysyx_23060136_exu_branch_bht;

   localparam int unsigned BITS_W = 32;
`ifdef YSYX_23060136_BHT_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [BITS_W-1:0] IFU_pc;
   logic              IFU_pre_take;
   logic              EXU2_valid, EXU2_is_branch, EXU2_jump, EXU2_pre_take;
   logic [BITS_W-1:0] EXU2_pc, EXU2_target;
   logic              redirect_valid;
   logic [BITS_W-1:0] redirect_pc;
   logic              BRANCH_flushIF, BRANCH_flushID, BRANCH_flushEX1;
   logic [31:0]       perf_branch_cnt, perf_miss_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ysyx_23060136_exu_branch_bht #(
      .BITS_W    (BITS_W),
      .BHT_DEPTH (4),
      .CNT_W     (2),
      .CNT_INIT  (1)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .IFU_pc          (IFU_pc),
      .IFU_pre_take    (IFU_pre_take),
      .EXU2_valid      (EXU2_valid),
      .EXU2_is_branch  (EXU2_is_branch),
      .EXU2_pc         (EXU2_pc),
      .EXU2_jump       (EXU2_jump),
      .EXU2_pre_take   (EXU2_pre_take),
      .EXU2_target     (EXU2_target),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .BRANCH_flushIF  (BRANCH_flushIF),
      .BRANCH_flushID  (BRANCH_flushID),
      .BRANCH_flushEX1 (BRANCH_flushEX1),
      .perf_branch_cnt (perf_branch_cnt),
      .perf_miss_cnt   (perf_miss_cnt)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_exu;
      EXU2_valid     = 1'b0;
      EXU2_is_branch = 1'b0;
      EXU2_pc        = '0;
      EXU2_jump      = 1'b0;
      EXU2_pre_take  = 1'b0;
      EXU2_target    = '0;
   endtask

   task automatic drive_br(input logic [31:0] pc, input logic jump, input logic pre,
                           input logic [31:0] tgt);
      EXU2_valid     = 1'b1;
      EXU2_is_branch = 1'b1;
      EXU2_pc        = pc;
      EXU2_jump      = jump;
      EXU2_pre_take  = pre;
      EXU2_target    = tgt;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      idle_exu();
      IFU_pc = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle_exu();
      tick();
      tick();
      n_checks++;
      if (redirect_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_redirect_valid got %b exp 0", redirect_valid);
      end
      n_checks++;
      if (redirect_pc !== 32'h0) begin
         n_fail++; $display("FAIL reset_redirect_pc got %h exp 00000000", redirect_pc);
      end
      n_checks++;
      if ({BRANCH_flushIF, BRANCH_flushID, BRANCH_flushEX1} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flush got %b exp 000",
                            {BRANCH_flushIF, BRANCH_flushID, BRANCH_flushEX1});
      end
      n_checks++;
      if (perf_branch_cnt !== 32'd0 || perf_miss_cnt !== 32'd0) begin
         n_fail++; $display("FAIL reset_perf got %0d/%0d exp 0/0", perf_branch_cnt, perf_miss_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         IFU_pc = 32'(i) << 2;
         #1;
         n_checks++;
         if (IFU_pre_take !== 1'b0) begin
            n_fail++; $display("FAIL reset_pred[%0d] got %b exp 0", i, IFU_pre_take);
         end
      end
      rst = 1'b0;
   endtask

   // Counter trace 1->2->3->3, then two not-taken 3->2->1 shows the saturation point exactly.
   task automatic test_train;
      logic exp_pred [6];
      logic jump_seq [5];
      exp_pred = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      jump_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      do_reset();
      IFU_pc = 32'h80000010;
      drive_br(32'h80000010, 1'b1, 1'b1, 32'h80000400);
      #1;
      n_checks++;
      if (IFU_pre_take !== 1'b0) begin
         n_fail++; $display("FAIL train_pre got %b exp 0", IFU_pre_take);
      end
      for (int i = 0; i < 5; i++) begin
         drive_br(32'h80000010, jump_seq[i], jump_seq[i], 32'h80000400);
         tick();
         n_checks++;
         if (IFU_pre_take !== exp_pred[i]) begin
            n_fail++; $display("FAIL train_pred[%0d] got %b exp %b", i, IFU_pre_take, exp_pred[i]);
         end
         n_checks++;
         if (redirect_valid !== 1'b0) begin
            n_fail++; $display("FAIL train_no_redirect[%0d] got %b exp 0", i, redirect_valid);
         end
      end
      idle_exu();
      tick();
      n_checks++;
      if (IFU_pre_take !== exp_pred[5]) begin
         n_fail++; $display("FAIL train_final got %b exp %b", IFU_pre_take, exp_pred[5]);
      end
   endtask

   task automatic test_mispredict;
      do_reset();
      drive_br(32'h80000020, 1'b1, 1'b0, 32'h80000100);
      tick();
      idle_exu();
      n_checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80000100) begin
         n_fail++; $display("FAIL miss_redirect got %b/%h exp 1/80000100", redirect_valid, redirect_pc);
      end
      n_checks++;
      if ({BRANCH_flushIF, BRANCH_flushID, BRANCH_flushEX1} !== 3'b111) begin
         n_fail++; $display("FAIL miss_flush got %b exp 111",
                            {BRANCH_flushIF, BRANCH_flushID, BRANCH_flushEX1});
      end
      n_checks++;
      if (perf_branch_cnt !== 32'(PERF) || perf_miss_cnt !== 32'(PERF)) begin
         n_fail++; $display("FAIL miss_perf got %0d/%0d exp %0d/%0d",
                            perf_branch_cnt, perf_miss_cnt, PERF, PERF);
      end
      tick();
      n_checks++;
      if ({redirect_valid, BRANCH_flushIF, BRANCH_flushID, BRANCH_flushEX1} !== 4'b0000) begin
         n_fail++; $display("FAIL miss_pulse got %b exp 0000",
                            {redirect_valid, BRANCH_flushIF, BRANCH_flushID, BRANCH_flushEX1});
      end
   endtask

   task automatic test_wrap;
      do_reset();
      drive_br(32'hFFFFFFFC, 1'b0, 1'b1, 32'h12345678);
      tick();
      idle_exu();
      n_checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h00000000) begin
         n_fail++; $display("FAIL wrap_redirect got %b/%h exp 1/00000000", redirect_valid, redirect_pc);
      end
   endtask

   task automatic test_squash;
      do_reset();
      IFU_pc = 32'h80000004;
      drive_br(32'h80000000, 1'b1, 1'b0, 32'h80000200);
      tick();
      drive_br(32'h80000004, 1'b1, 1'b0, 32'h80000300);
      n_checks++;
      if (redirect_valid !== 1'b1) begin
         n_fail++; $display("FAIL squash_first got %b exp 1", redirect_valid);
      end
      tick();
      idle_exu();
      n_checks++;
      if (redirect_valid !== 1'b0) begin
         n_fail++; $display("FAIL squash_no_redirect got %b exp 0", redirect_valid);
      end
      n_checks++;
      if (IFU_pre_take !== 1'b0) begin
         n_fail++; $display("FAIL squash_bypass got %b exp 0", IFU_pre_take);
      end
      tick();
      n_checks++;
      if (IFU_pre_take !== 1'b0) begin
         n_fail++; $display("FAIL squash_counter got %b exp 0", IFU_pre_take);
      end
      n_checks++;
      if (perf_branch_cnt !== 32'(PERF) || perf_miss_cnt !== 32'(PERF)) begin
         n_fail++; $display("FAIL squash_perf got %0d/%0d exp %0d/%0d",
                            perf_branch_cnt, perf_miss_cnt, PERF, PERF);
      end
   endtask

   task automatic test_alias;
      do_reset();
      IFU_pc = 32'h00000000;
      drive_br(32'h00000010, 1'b1, 1'b1, 32'h00000040);
      tick();
      idle_exu();
      n_checks++;
      if (IFU_pre_take !== 1'b1) begin
         n_fail++; $display("FAIL alias_bypass got %b exp 1", IFU_pre_take);
      end
      tick();
      n_checks++;
      if (IFU_pre_take !== 1'b1) begin
         n_fail++; $display("FAIL alias_stored got %b exp 1", IFU_pre_take);
      end
      // Reset arriving with a taken update latched must leave the entry at CNT_INIT.
      do_reset();
      drive_br(32'h00000010, 1'b1, 1'b1, 32'h00000040);
      tick();
      idle_exu();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (IFU_pre_take !== 1'b0) begin
         n_fail++; $display("FAIL alias_rst_pending got %b exp 0", IFU_pre_take);
      end
      tick();
      n_checks++;
      if (IFU_pre_take !== 1'b0) begin
         n_fail++; $display("FAIL alias_rst_counter got %b exp 0", IFU_pre_take);
      end
      // A mispredict presented together with reset must not produce a redirect.
      rst = 1'b1;
      drive_br(32'h00000008, 1'b1, 1'b0, 32'h00000080);
      tick();
      rst = 1'b0;
      idle_exu();
      n_checks++;
      if (redirect_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_redirect got %b exp 0", redirect_valid);
      end
   endtask

   initial begin
      rst    = 1'b1;
      IFU_pc = '0;
      idle_exu();
      test_reset();
      test_train();
      test_mispredict();
      test_wrap();
      test_squash();
      test_alias();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
